// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the ECP5 EHXPLLL: pulses PLL reset, waits for stable lock, releases core reset.
// Optional retry limit with a FAIL state: define PLL_RESET_SEQ_RETRY_LIMIT_EN.
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_WIDTH           = 17,
    parameter int unsigned MAX_RETRIES         = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       pll_ready,
    output logic [2:0] state,
    output logic [7:0] relock_count,
    output logic       pll_fail
);

    localparam int unsigned TCNT_W = 8;

    localparam logic [2:0] PLL_RESET = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABLE    = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] FAIL      = 3'd4;

    localparam logic [CNT_WIDTH-1:0] PULSE_LAST   = CNT_WIDTH'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};
    localparam logic [TCNT_W-1:0]    RETRY_LAST   = TCNT_W'(MAX_RETRIES - 1);

    logic                 lock_meta;
    logic                 lock_s;
    logic [2:0]           state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [TCNT_W-1:0]    tcnt;
    logic                 cnt_clr;
    logic                 timeout_hit;
    logic                 relock_hit;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= PLL_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; soft request outranks lock loss, which outranks counter expiry
    always_comb begin
        state_nxt   = state;
        cnt_clr     = 1'b0;
        timeout_hit = 1'b0;
        relock_hit  = 1'b0;
        if (soft_rst_req) begin
            state_nxt = PLL_RESET;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                PLL_RESET: begin
                    if (cnt == PULSE_LAST) begin
                        state_nxt = WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout_hit = 1'b1;
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
                        state_nxt   = (tcnt == RETRY_LAST) ? FAIL : PLL_RESET;
`else
                        state_nxt   = PLL_RESET;
`endif
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_nxt = WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_nxt  = PLL_RESET;
                        relock_hit = 1'b1;
                    end
                end
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
                FAIL: begin
                    state_nxt = FAIL;
                end
`endif
                default: begin
                    state_nxt = PLL_RESET;
                end
            endcase
        end
    end

    // Shared counter: clears on any state change, saturates instead of wrapping
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_clr || (state_nxt != state)) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

    // Consecutive-timeout count; cleared when RUN is reached or FAIL is left
    always_ff @(posedge clock) begin
        if (reset) begin
            tcnt <= '0;
        end else if (((state_nxt == RUN) && (state != RUN)) ||
                     ((state == FAIL) && (state_nxt != FAIL))) begin
            tcnt <= '0;
        end else if (timeout_hit && (tcnt != RETRY_LAST)) begin
            tcnt <= tcnt + TCNT_W'(1);
        end
    end

    // Saturating count of lock-loss re-sequences
    always_ff @(posedge clock) begin
        if (reset) begin
            relock_count <= '0;
        end else if (relock_hit && (relock_count != 8'hFF)) begin
            relock_count <= relock_count + 8'(1);
        end
    end

    // Outputs decoded from the next state so they move with state
    always_ff @(posedge clock) begin
        if (reset) begin
            pll_rst   <= 1'b1;
            core_rst  <= 1'b1;
            pll_ready <= 1'b0;
        end else begin
            pll_rst   <= (state_nxt == PLL_RESET) || (state_nxt == FAIL);
            core_rst  <= (state_nxt != RUN);
            pll_ready <= (state_nxt == RUN);
        end
    end

`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            pll_fail <= 1'b0;
        end else begin
            pll_fail <= (state_nxt == FAIL);
        end
    end
`else
    assign pll_fail = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short sequencing parameters (pulse 4, stable 8, timeout 32).
module tb_pll_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       pll_lock;
    logic       soft_rst_req;
    logic       pll_rst;
    logic       core_rst;
    logic       pll_ready;
    logic [2:0] state;
    logic [7:0] relock_count;
    logic       pll_fail;

    int compared   = 0;
    int mismatched = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(32),
        .CNT_WIDTH          (6),
        .MAX_RETRIES        (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .soft_rst_req(soft_rst_req),
        .pll_rst     (pll_rst),
        .core_rst    (core_rst),
        .pll_ready   (pll_ready),
        .state       (state),
        .relock_count(relock_count),
        .pll_fail    (pll_fail)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        pll_lock     = 1'b1;
        soft_rst_req = 1'b0;
        tick(3);
        check("rst_state", 8'(state), 8'd0);
        check("rst_pll_rst", 8'(pll_rst), 8'd1);
        check("rst_core_rst", 8'(core_rst), 8'd1);
        check("rst_ready", 8'(pll_ready), 8'd0);
        check("rst_relock", relock_count, 8'd0);
        check("rst_fail", 8'(pll_fail), 8'd0);

        // Bring-up with lock held high
        reset = 1'b0;
        tick(1);
        check("e1_pll_rst", 8'(pll_rst), 8'd1);
        tick(2);
        check("e3_pll_rst", 8'(pll_rst), 8'd1);
        check("e3_state", 8'(state), 8'd0);
        tick(1);
        check("e4_pll_rst", 8'(pll_rst), 8'd0);
        check("e4_state", 8'(state), 8'd1);
        tick(1);
        check("e5_state", 8'(state), 8'd2);
        tick(7);
        check("e12_core_rst", 8'(core_rst), 8'd1);
        check("e12_state", 8'(state), 8'd2);
        tick(1);
        check("e13_core_rst", 8'(core_rst), 8'd0);
        check("e13_ready", 8'(pll_ready), 8'd1);
        check("e13_state", 8'(state), 8'd3);

        // One-cycle lock drop in RUN
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(1);
        check("drop_e15_state", 8'(state), 8'd3);
        tick(1);
        check("drop_e16_state", 8'(state), 8'd0);
        check("drop_e16_core_rst", 8'(core_rst), 8'd1);
        check("drop_e16_pll_rst", 8'(pll_rst), 8'd1);
        check("drop_e16_relock", relock_count, 8'd1);
        tick(4);
        check("reseq_wait", 8'(state), 8'd1);
        tick(1);
        check("reseq_stable", 8'(state), 8'd2);
        tick(7);
        check("reseq_pre_run", 8'(core_rst), 8'd1);
        tick(1);
        check("reseq_run", 8'(state), 8'd3);
        check("reseq_ready", 8'(pll_ready), 8'd1);

        // Soft request coincident with lock loss seen in RUN
        pll_lock = 1'b0;
        tick(2);
        check("coinc_pre_state", 8'(state), 8'd3);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        pll_lock     = 1'b1;
        check("coinc_state", 8'(state), 8'd0);
        check("coinc_relock", relock_count, 8'd1);
        check("coinc_pll_rst", 8'(pll_rst), 8'd1);
        tick(4);
        check("coinc_wait", 8'(state), 8'd1);
        tick(1);
        check("coinc_stable", 8'(state), 8'd2);

        // Lock glitch early in STABLE: back to WAIT_LOCK without a PLL reset pulse
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(1);
        check("glitch_still_stable", 8'(state), 8'd2);
        tick(1);
        check("glitch_wait", 8'(state), 8'd1);
        check("glitch_no_pll_rst", 8'(pll_rst), 8'd0);
        tick(1);
        check("glitch_stable", 8'(state), 8'd2);
        tick(7);
        check("glitch_pre_run", 8'(state), 8'd2);
        tick(1);
        check("glitch_run", 8'(state), 8'd3);
        check("glitch_relock", relock_count, 8'd1);

        // Lock lost for good: relock, then repeated timeouts
        pll_lock = 1'b0;
        tick(3);
        check("loss_state", 8'(state), 8'd0);
        check("loss_relock", relock_count, 8'd2);
        tick(4);
        check("to1_wait", 8'(state), 8'd1);
        check("to1_pll_rst", 8'(pll_rst), 8'd0);
        tick(31);
        check("to1_pre", 8'(state), 8'd1);
        tick(1);
        check("to1_state", 8'(state), 8'd0);
        check("to1_pll_rst_hi", 8'(pll_rst), 8'd1);
        tick(4);
        check("to2_wait", 8'(state), 8'd1);
        tick(32);
`ifdef PLL_RESET_SEQ_RETRY_LIMIT_EN
        check("to2_state_fail", 8'(state), 8'd4);
        check("to2_pll_fail", 8'(pll_fail), 8'd1);
`else
        check("to2_state_reset", 8'(state), 8'd0);
        check("to2_pll_fail", 8'(pll_fail), 8'd0);
`endif
        check("to2_pll_rst", 8'(pll_rst), 8'd1);
        check("to2_core_rst", 8'(core_rst), 8'd1);
        check("to2_ready", 8'(pll_ready), 8'd0);
        check("to2_relock", relock_count, 8'd2);

        // Soft request leaves FAIL / restarts the reset pulse
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        check("soft_state", 8'(state), 8'd0);
        check("soft_pll_fail", 8'(pll_fail), 8'd0);
        check("soft_pll_rst", 8'(pll_rst), 8'd1);
        tick(2);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        tick(3);
        check("restart_hold", 8'(state), 8'd0);
        tick(1);
        check("restart_wait", 8'(state), 8'd1);
        check("restart_relock", relock_count, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sequences the ECP5 EHXPLLL clock generator at bring-up and after lock loss.
- Runs on the free-running board reference clock that also feeds the PLL.
- Pulses the PLL reset, waits for a stable lock, then releases the core reset.
- On lock loss or timeout, re-asserts the core reset and re-sequences the PLL.
- Sits between the board clock/reset pins and the core reset synchroniser.

Parameters:
- RST_PULSE_CYCLES, 16: cycles pll_rst is held high per PLL reset attempt (min 1).
- LOCK_STABLE_CYCLES, 1024: consecutive cycles of synchronised lock required before releasing core_rst (min 1).
- LOCK_TIMEOUT_CYCLES, 65536: cycles waiting for lock before retrying the PLL reset (min 2).
- CNT_WIDTH, 17: shared counter width; must hold max(all of the above) - 1.
- MAX_RETRIES, 4: consecutive timeouts allowed before failure (used only with the optional feature).

Ports:
- clock  in  1  reference clock, free running
- reset  in  1  synchronous, active-high block reset
- pll_lock  in  1  PLL LOCK, asynchronous to clock
- soft_rst_req  in  1  single-cycle pulse requesting a full re-sequence
- pll_rst  out  1  to PLL RST, active high
- core_rst  out  1  core reset, active high
- pll_ready  out  1  high only in RUN
- state  out  3  encoded current state (debug)
- relock_count  out  8  saturating count of lock-loss re-sequences
- pll_fail  out  1  retry limit exhausted (optional feature)

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high, named clock and reset.
- pll_lock passes through a 2-flop synchroniser (reset to 0) to give lock_s.
- States: PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- One CNT_WIDTH counter; it clears on every state change and increments otherwise.
- All outputs are registered, decoded from the next state, so they change on the same edge as state.
- While reset is high: state=PLL_RESET, cnt=0, pll_rst=1, core_rst=1, pll_ready=0, relock_count=0, pll_fail=0, sync flops=0, timeout counter=0.
- PLL_RESET: pll_rst=1. When cnt==RST_PULSE_CYCLES-1, go to WAIT_LOCK. pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles after entry.
- WAIT_LOCK: pll_rst=0.
  - lock_s=1: go to STABLE.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1: go to PLL_RESET and increment the consecutive-timeout counter.
- STABLE:
  - lock_s=0: go to WAIT_LOCK (counter restarts; no new PLL reset).
  - cnt==LOCK_STABLE_CYCLES-1 and lock_s=1: go to RUN.
- RUN: core_rst=0, pll_ready=1; the consecutive-timeout counter clears on entry. lock_s=0: go to PLL_RESET, relock_count+1, saturating at 255.
- core_rst=1 in every state except RUN.
- soft_rst_req=1 in any state except PLL_RESET: go to PLL_RESET with the counter cleared; relock_count is not incremented.
  - Priority when events coincide: reset > soft_rst_req > lock loss > counter expiry.
  - soft_rst_req while already in PLL_RESET restarts the pulse count (cnt=0).
- The counter never wraps: every state leaves, or holds its value, at its terminal count.
- Consumers in other clock domains must resynchronise core_rst.
- state encodings 5–7 are unreachable; if entered, go to PLL_RESET.

Optional Feature:
- Macro: PLL_RESET_SEQ_RETRY_LIMIT_EN.
- Defined:
  - A WAIT_LOCK timeout while the consecutive-timeout count equals MAX_RETRIES-1 goes to FAIL instead of PLL_RESET.
  - In FAIL: pll_rst=1, core_rst=1, pll_ready=0, pll_fail=1.
  - Only reset or soft_rst_req leaves FAIL; either goes to PLL_RESET and clears the timeout count.
- Undefined: retries continue forever, FAIL is unreachable, pll_fail is tied 0.

Test Plan:
- Params RST_PULSE=4, STABLE=8, TIMEOUT=32; pll_lock held 1; reset released before edge 1 -> pll_rst high through edge 3, low from edge 4; state=STABLE at edge 5; core_rst falls and pll_ready rises at edge 13.
- Same params, pll_lock=0 -> pll_rst re-pulses for 4 cycles every 36 cycles; core_rst stays 1; relock_count stays 0.
- Reach RUN, then drop pll_lock for 1 cycle -> core_rst=1 within 3 edges (2 sync + 1); state=PLL_RESET; relock_count=1; full re-sequence to RUN once lock returns.
- In STABLE at cnt=5, glitch lock low for 1 cycle -> state goes to WAIT_LOCK with no pll_rst pulse; RUN is reached 8 cycles after lock_s returns, plus 1 cycle for the WAIT_LOCK→STABLE step.
- In RUN, pulse soft_rst_req coincident with lock loss -> soft request wins: PLL_RESET entered, relock_count unchanged.
- With PLL_RESET_SEQ_RETRY_LIMIT_EN and MAX_RETRIES=2, lock held 0 -> FAIL after the 2nd timeout with pll_fail=1 and pll_rst=1; soft_rst_req -> PLL_RESET with pll_fail=0.
